// File: rtl/pipe_mips20_pkg.sv
// Shared definitions for the pipe_mips20 core: opcodes, instruction fields,
// instruction classes and pipeline latch layouts.
// PIPE_MIPS20_MUL_EN enables the MUL instruction; without it MUL decodes as a no-op.
package pipe_mips20_pkg;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // NONE is encoding 0 so an all-zero latch is a pipeline bubble
  typedef enum logic [2:0] {NONE, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} itype_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op2;
    logic [31:0] imm;
    alu_op_e     aop;
    itype_e      typ;
    logic [4:0]  dst;
    logic        beqz;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  dst;
    itype_e      typ;
    logic        cond;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] lmd;
    logic [4:0]  dst;
    itype_e      typ;
  } mem_wb_t;

  function automatic itype_e decode(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: return RR_ALU;
`ifdef PIPE_MIPS20_MUL_EN
      OP_MUL:                                return RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             return RM_ALU;
      OP_LW:                                 return LOAD;
      OP_SW:                                 return STORE;
      OP_BNEQZ, OP_BEQZ:                     return BRANCH;
      OP_HLT:                                return HALT;
      default:                               return NONE;
    endcase
  endfunction

  // loads, stores and branches all need an add
  function automatic alu_op_e alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mips20_alu.sv
// Combinational ALU of the pipe_mips20 core; all arithmetic wraps at 32 bits.
// PIPE_MIPS20_MUL_EN adds the low-32-bit multiplier.
module pipe_mips20_alu import pipe_mips20_pkg::*; (
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
`ifdef PIPE_MIPS20_MUL_EN
      ALU_MUL: y = a * b;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips20.sv
// Five-stage in-order MIPS-like core (IF/ID/EX/MEM/WB) with a unified word
// memory, no forwarding and no interlocks. Branches resolve in MEM and flush
// the three younger instructions. PIPE_MIPS20_MUL_EN enables MUL.
module pipe_mips20 #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk1,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result,
  output logic        halted_out,
  output logic [31:0] debug_operand1,
  output logic [31:0] debug_operand2
);
  import pipe_mips20_pkg::*;

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:31];

  logic [31:0] pc;
  logic        halted;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;

  logic [5:0]  op_i;
  logic [4:0]  rs_i, rt_i, rd_i, dst_i;
  logic [31:0] imm_i, rs_val, rt_val;
  itype_e      typ_i;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        taken;
  logic [31:0] wb_data;

  function automatic logic [AW-1:0] maddr(input logic [31:0] a);
    return AW'(a % 32'(MEM_DEPTH));
  endfunction

  // ID: field extraction, decode and register read (values committed on prior edges)
  always_comb begin
    op_i   = if_id.ir[OP_MSB:OP_LSB];
    rs_i   = if_id.ir[RS_MSB:RS_LSB];
    rt_i   = if_id.ir[RT_MSB:RT_LSB];
    rd_i   = if_id.ir[RD_MSB:RD_LSB];
    imm_i  = {{16{if_id.ir[IMM_MSB]}}, if_id.ir[IMM_MSB:IMM_LSB]};
    typ_i  = decode(op_i);
    rs_val = (rs_i == '0) ? '0 : Reg[rs_i];
    rt_val = (rt_i == '0) ? '0 : Reg[rt_i];
    dst_i  = '0;
    case (typ_i)
      RR_ALU:       dst_i = rd_i;
      RM_ALU, LOAD: dst_i = rt_i;
      default:      dst_i = '0;
    endcase
  end

  // EX operand muxing: branches add the immediate to PC+1
  always_comb begin
    alu_a = (id_ex.typ == BRANCH) ? id_ex.npc : id_ex.a;
    alu_b = (id_ex.typ == BRANCH) ? id_ex.imm : id_ex.op2;
  end

  pipe_mips20_alu u_alu (
    .op (id_ex.aop),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // MEM-stage branch resolution and WB data select
  always_comb begin
    taken   = (ex_mem.typ == BRANCH) && ex_mem.cond;
    wb_data = (mem_wb.typ == LOAD) ? mem_wb.lmd : mem_wb.alu;
  end

  // pipeline latches, PC and halt flag; everything freezes once halted
  always_ff @(posedge clk1) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!halted) begin
      if (mem_wb.typ == HALT) halted <= 1'b1;
      mem_wb.alu <= ex_mem.alu;
      mem_wb.lmd <= Mem[maddr(ex_mem.alu)];
      mem_wb.dst <= ex_mem.dst;
      mem_wb.typ <= ex_mem.typ;
      if (taken) begin
        // wrong-path instructions become bubbles; fetch restarts at the target
        pc     <= ex_mem.alu;
        if_id  <= '0;
        id_ex  <= '0;
        ex_mem <= '0;
      end else begin
        pc           <= pc + 32'd1;
        if_id.ir     <= Mem[maddr(pc)];
        if_id.npc    <= pc + 32'd1;
        id_ex.npc    <= if_id.npc;
        id_ex.a      <= rs_val;
        id_ex.b      <= rt_val;
        id_ex.op2    <= (typ_i == RM_ALU || typ_i == LOAD || typ_i == STORE) ? imm_i : rt_val;
        id_ex.imm    <= imm_i;
        id_ex.aop    <= alu_sel(op_i);
        id_ex.typ    <= typ_i;
        id_ex.dst    <= dst_i;
        id_ex.beqz   <= (op_i == OP_BEQZ);
        ex_mem.alu   <= alu_y;
        ex_mem.b     <= id_ex.b;
        ex_mem.dst   <= id_ex.dst;
        ex_mem.typ   <= id_ex.typ;
        ex_mem.cond  <= id_ex.beqz ? (id_ex.a == '0) : (id_ex.a != '0);
      end
    end
  end

  // register file write-back; Reg[0] is never written
  always_ff @(posedge clk1) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) Reg[i[4:0]] <= '0;
    end else if (!halted && mem_wb.dst != '0) begin
      Reg[mem_wb.dst] <= wb_data;
    end
  end

  // data memory store; not reset so preloaded programs survive reset.
  // A store issued behind HLT is dropped on the edge HLT retires.
  always_ff @(posedge clk1) begin
    if (!reset && !halted && ex_mem.typ == STORE && mem_wb.typ != HALT)
      Mem[maddr(ex_mem.alu)] <= ex_mem.b;
  end

  assign pc_out         = pc;
  assign alu_result     = ex_mem.alu;
  assign halted_out     = halted;
  assign debug_operand1 = id_ex.a;
  assign debug_operand2 = id_ex.op2;

endmodule

// File: tb/tb_pipe_mips20.sv
// Self-checking bench for pipe_mips20: programs are preloaded into Mem, the
// expected architectural state is queued, and compared once the core halts.
module tb_pipe_mips20;
  import pipe_mips20_pkg::*;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_out, alu_result, debug_operand1, debug_operand2;
  logic        halted_out;

  pipe_mips20 #(.MEM_DEPTH(1024)) dut (
    .clk1           (clk1),
    .reset          (reset),
    .pc_out         (pc_out),
    .alu_result     (alu_result),
    .halted_out     (halted_out),
    .debug_operand1 (debug_operand1),
    .debug_operand2 (debug_operand2)
  );

  always #5 clk1 = ~clk1;

`ifdef PIPE_MIPS20_MUL_EN
  localparam logic [31:0] MUL_EXP = 32'd50;
`else
  localparam logic [31:0] MUL_EXP = 32'd0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  typedef struct {
    string       tag;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  logic [31:0] h_d1[64], h_d2[64], h_alu[64];
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
    sb.push_back('{tag: tag, is_mem: 1'b0, idx: idx, val: v});
  endtask

  task automatic exp_mem(input string tag, input int idx, input logic [31:0] v);
    sb.push_back('{tag: tag, is_mem: 1'b1, idx: idx, val: v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_mem) check(e.tag, dut.Mem[10'(e.idx)], e.val);
      else          check(e.tag, dut.Reg[5'(e.idx)], e.val);
    end
  endtask

  task automatic load_prog();
    @(negedge clk1);
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
    foreach (prog[i]) dut.Mem[i] = prog[i];
  endtask

  task automatic release_reset();
    @(negedge clk1);
    @(negedge clk1);
    check("rst_pc", pc_out, 32'd0);
    check("rst_halted", {31'd0, halted_out}, 32'd0);
    check("rst_alu", alu_result, 32'd0);
    check("rst_dbg1", debug_operand1, 32'd0);
    check("rst_dbg2", debug_operand2, 32'd0);
    check("rst_reg1", dut.Reg[1], 32'd0);
    check("rst_reg3", dut.Reg[3], 32'd0);
    reset = 1'b0;
  endtask

  task automatic run(input int limit, output int n);
    n = 0;
    while (!halted_out && n < limit) begin
      @(posedge clk1);
      #1;
      n++;
      if (n < 64) begin
        h_d1[n]  = debug_operand1;
        h_d2[n]  = debug_operand2;
        h_alu[n] = alu_result;
      end
    end
    check("halt_seen", {31'd0, halted_out}, 32'd1);
  endtask

  task automatic build_alu();
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, -3));
    prog.push_back(enc_i(OP_ADDI, 0, 2, 5));
    repeat (3) prog.push_back(NOP);
    prog.push_back(enc_r(OP_SUB, 1, 2, 3));
    prog.push_back(enc_r(OP_AND, 1, 2, 4));
    prog.push_back(enc_r(OP_OR, 1, 2, 5));
    prog.push_back(enc_r(OP_SLT, 1, 2, 6));
    prog.push_back(enc_r(OP_SLT, 2, 1, 7));
    prog.push_back(enc_i(OP_SLTI, 1, 8, -2));
    prog.push_back(enc_i(OP_SUBI, 2, 9, 7));
    prog.push_back(enc_r(OP_ADD, 1, 2, 10));
    prog.push_back(enc_r(6'b010101, 1, 11, 11));
    prog.push_back(HLT);
  endtask

  task automatic expect_alu();
    exp_reg("alu_r1", 1, 32'hFFFF_FFFD);
    exp_reg("alu_sub", 3, 32'hFFFF_FFF8);
    exp_reg("alu_and", 4, 32'h0000_0005);
    exp_reg("alu_or", 5, 32'hFFFF_FFFD);
    exp_reg("alu_slt_t", 6, 32'd1);
    exp_reg("alu_slt_f", 7, 32'd0);
    exp_reg("alu_slti", 8, 32'd1);
    exp_reg("alu_subi", 9, 32'hFFFF_FFFE);
    exp_reg("alu_add", 10, 32'd2);
    exp_reg("alu_unknown", 11, 32'd0);
  endtask

  initial begin
    // MUL program and pipeline timing
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 10));
    repeat (3) prog.push_back(NOP);
    prog.push_back(enc_i(OP_ADDI, 0, 2, 5));
    repeat (3) prog.push_back(NOP);
    prog.push_back(32'h1422_1800);
    repeat (3) prog.push_back(NOP);
    prog.push_back(HLT);
    load_prog();
    release_reset();
    exp_reg("mul_r1", 1, 32'd10);
    exp_reg("mul_r2", 2, 32'd5);
    exp_reg("mul_r3", 3, MUL_EXP);
    run(200, cyc);
    drain();
    check("mul_halt_cycle", 32'(cyc), 32'd17);
    check("mul_dbg2_addi", h_d2[2], 32'd10);
    check("mul_alu_addi", h_alu[3], 32'd10);
    check("mul_dbg1", h_d1[10], 32'd10);
    check("mul_dbg2", h_d2[10], 32'd5);
`ifdef PIPE_MIPS20_MUL_EN
    check("mul_alu", h_alu[11], 32'd50);
`endif
    check("halt_pc", pc_out, 32'd17);
    repeat (3) @(posedge clk1);
    #1;
    check("halt_pc_hold", pc_out, 32'd17);
    check("halt_hold", {31'd0, halted_out}, 32'd1);

    // writes to R0 are discarded
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 0, 7));
    prog.push_back(HLT);
    load_prog();
    release_reset();
    exp_reg("r0_zero", 0, 32'd0);
    run(100, cyc);
    drain();
    check("r0_halt_cycle", 32'(cyc), 32'd6);

    // store / load with negative offset and address wrap
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 16'h1234));
    prog.push_back(enc_i(OP_ADDI, 0, 5, 101));
    repeat (3) prog.push_back(NOP);
    prog.push_back(enc_i(OP_SW, 5, 1, -1));
    prog.push_back(enc_i(OP_SW, 0, 1, 1074));
    repeat (2) prog.push_back(NOP);
    prog.push_back(enc_i(OP_LW, 5, 4, -1));
    prog.push_back(HLT);
    load_prog();
    release_reset();
    exp_reg("lw_r4", 4, 32'h0000_1234);
    exp_mem("sw_mem100", 100, 32'h0000_1234);
    exp_mem("sw_wrap50", 50, 32'h0000_1234);
    run(200, cyc);
    drain();

    // ALU operations and unknown opcode
    build_alu();
    load_prog();
    release_reset();
    expect_alu();
    run(200, cyc);
    drain();

    // countdown loop, squashed wrong-path writes, taken BEQZ
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 3));
    prog.push_back(enc_i(OP_ADDI, 0, 2, 0));
    repeat (3) prog.push_back(NOP);
    prog.push_back(enc_i(OP_SUBI, 1, 1, 1));
    prog.push_back(enc_i(OP_ADDI, 2, 2, 1));
    repeat (2) prog.push_back(NOP);
    prog.push_back(enc_i(OP_BNEQZ, 1, 0, -5));
    prog.push_back(enc_i(OP_ADDI, 3, 3, 1));
    prog.push_back(enc_i(OP_ADDI, 4, 4, 1));
    prog.push_back(enc_i(OP_SW, 1, 1, 300));
    prog.push_back(enc_i(OP_BEQZ, 0, 0, 3));
    prog.push_back(enc_i(OP_ADDI, 0, 5, 1));
    prog.push_back(enc_i(OP_ADDI, 0, 6, 1));
    prog.push_back(enc_i(OP_ADDI, 0, 7, 1));
    prog.push_back(HLT);
    load_prog();
    for (int i = 300; i < 303; i++) dut.Mem[i] = 32'h0000_DEAD;
    release_reset();
    exp_reg("loop_r1", 1, 32'd0);
    exp_reg("loop_r2", 2, 32'd3);
    exp_reg("shadow_r3", 3, 32'd1);
    exp_reg("shadow_r4", 4, 32'd1);
    exp_mem("shadow_m300", 300, 32'd0);
    exp_mem("shadow_m301", 301, 32'h0000_DEAD);
    exp_mem("shadow_m302", 302, 32'h0000_DEAD);
    exp_reg("beqz_r5", 5, 32'd0);
    exp_reg("beqz_r6", 6, 32'd0);
    exp_reg("beqz_r7", 7, 32'd0);
    run(500, cyc);
    drain();

    // reset pulsed mid-program, then rerun to completion
    build_alu();
    load_prog();
    release_reset();
    repeat (9) @(posedge clk1);
    #1;
    check("mid_pre_r1", dut.Reg[1], 32'hFFFF_FFFD);
    @(negedge clk1);
    reset = 1'b1;
    release_reset();
    expect_alu();
    run(200, cyc);
    drain();
    check("mid_halt_cycle", 32'(cyc), 32'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
